// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared definitions for the pipeline control block:
//   - state_t      : FSM state encodings (RUN / MEM_WAIT / ERROR)
//   - ctrl_t       : bundle of the five pipeline-register control lines
//   - DEF_CNT_W, DEF_MEM_TIMEOUT, WAIT_W : default parameters and wait counter width
//   - run_decode() : normal-operation control decode, shared by RUN and the
//                    MEM_WAIT completion cycle
package pipeline_ctrl_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_MEM_TIMEOUT = 63;
    localparam int WAIT_W          = 6;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_freeze;
        logic if_id_freeze;
        logic if_id_flush;
        logic id_ex_flush;
        logic pipe_freeze;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE   = '{default: 1'b0};
    localparam ctrl_t CTRL_FREEZE = '{pc_freeze: 1'b1, if_id_freeze: 1'b1,
                                      if_id_flush: 1'b0, id_ex_flush: 1'b0,
                                      pipe_freeze: 1'b1};

    // Priority: memory stall, then taken branch (which makes any hazard moot,
    // since the dependent instruction is being squashed), then hazard bubble.
    function automatic ctrl_t run_decode(input logic mem_stall,
                                         input logic branch_taken,
                                         input logic hazard_detected);
        ctrl_t c;
        c = CTRL_IDLE;
        if (mem_stall) begin
            c = CTRL_FREEZE;
        end else if (branch_taken) begin
            c.if_id_flush = 1'b1;
            c.id_ex_flush = 1'b1;
        end else if (hazard_detected) begin
            c.pc_freeze    = 1'b1;
            c.if_id_freeze = 1'b1;
            c.id_ex_flush  = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset, zeroes count
//   clr   : synchronous clear, wins over inc
//   inc   : count up by one this cycle (held at all-ones once reached)
//   count : current count value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Pipeline hazard / stall / flush controller with memory-wait timeout and
// two saturating performance counters.
//   clk, rst        : clock (rising edge) and asynchronous active-low reset
//   hazard_detected : load-use / RAW hazard from the hazard unit
//   branch_taken    : taken branch resolved in EXE
//   mem_req         : MEM stage issues an access this cycle
//   mem_ready       : memory reports the access complete
//   clr_cnt         : synchronous clear of stall_cnt and flush_cnt
//   pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze :
//                     Mealy control lines to the pipeline registers
//   mem_err         : sticky memory-timeout error
//   state           : registered FSM state (debug / observation)
//   stall_cnt       : cycles with pc_freeze high
//   flush_cnt       : cycles with if_id_flush high
//
// Memory handshake: mem_req is a request-valid held by the MEM stage; the
// access completes on the cycle mem_ready is high. A request seen with
// mem_ready low in RUN stalls the pipe and moves to MEM_WAIT, where the FSM
// waits for mem_ready regardless of mem_req. A mem_ready on the same cycle
// as the request completes without any stall.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             clr_cnt,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_freeze,
    output logic             mem_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    ctrl_t             ctrl;
    logic              mem_stall;

    assign mem_stall = mem_req && !mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            mem_err <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_d == ST_ERROR) begin
                mem_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        ctrl    = CTRL_IDLE;
        case (state_q)
            ST_RUN: begin
                ctrl = run_decode(mem_stall, branch_taken, hazard_detected);
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    // Access completes: behave as RUN this very cycle.
                    ctrl    = run_decode(1'b0, branch_taken, hazard_detected);
                    state_d = ST_RUN;
                end else begin
                    ctrl = CTRL_FREEZE;
                    if (wait_q == TIMEOUT_CNT) begin
                        state_d = ST_ERROR;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            default: begin
                // ERROR and the unused code 2'd3: frozen until reset.
                ctrl    = CTRL_FREEZE;
                state_d = ST_ERROR;
            end
        endcase
    end

    assign pc_freeze    = ctrl.pc_freeze;
    assign if_id_freeze = ctrl.if_id_freeze;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign pipe_freeze  = ctrl.pipe_freeze;
    assign state        = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_cnt),
        .inc   (ctrl.pc_freeze),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_cnt),
        .inc   (ctrl.if_id_flush),
        .count (flush_cnt)
    );

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameters SHALL be: CNT_W, default 16, width of the performance counters; MEM_TIMEOUT, default 63, the maximum number of memory-wait cycles before the error state.
REQ-002 Ports SHALL be as follows. There is one clock; reset is asynchronous and active-low.
- clk  input  1  sole clock; rising edge.
- rst  input  1  asynchronous, active-low reset.
- hazard_detected  input  1  load-use or RAW hazard flag from the hazard unit.
- branch_taken  input  1  taken branch resolved in the EXE stage.
- mem_req  input  1  MEM stage is issuing a read or write this cycle.
- mem_ready  input  1  memory/SRAM controller reports the access complete.
- clr_cnt  input  1  synchronous clear of both counters.
- pc_freeze  output  1  hold the PC.
- if_id_freeze  output  1  hold the IF/ID register.
- if_id_flush  output  1  load a NOP into IF/ID.
- id_ex_flush  output  1  load a NOP (bubble) into ID/EX.
- pipe_freeze  output  1  hold ID/EX, EXE/MEM and MEM/WB.
- mem_err  output  1  sticky memory-timeout error.
- state  output  2  current FSM state.
- stall_cnt  output  CNT_W  count of PC-freeze cycles.
- flush_cnt  output  CNT_W  count of branch flushes.

Function
REQ-003 The FSM SHALL have three states, encoded as RUN=2'd0, MEM_WAIT=2'd1 and ERROR=2'd2; the code 2'd3 SHALL behave as ERROR.
REQ-004 The control outputs SHALL be Mealy outputs, decoded from the state and current inputs; no control output SHALL be registered.
REQ-005 In RUN with mem_req=1 and mem_ready=0, the block SHALL assert pc_freeze, if_id_freeze and pipe_freeze, deassert both flushes, and go to MEM_WAIT next cycle; this condition has the highest priority.
REQ-006 In RUN with no pending memory wait and branch_taken=1, the block SHALL assert if_id_flush and id_ex_flush, deassert all freezes, and ignore hazard_detected.
REQ-007 In RUN with no memory wait, branch_taken=0 and hazard_detected=1, the block SHALL assert pc_freeze, if_id_freeze and id_ex_flush, with pipe_freeze=0 and if_id_flush=0.
REQ-008 In RUN with none of those conditions, all control outputs SHALL be 0.
REQ-009 In MEM_WAIT with mem_ready=0, the block SHALL assert pc_freeze, if_id_freeze and pipe_freeze, keep both flushes at 0, and increment wait_cnt.
REQ-010 In MEM_WAIT with mem_ready=1, outputs SHALL follow REQ-006 to REQ-008 on the same cycle; the next state SHALL be RUN and wait_cnt SHALL clear.
REQ-011 In MEM_WAIT, when wait_cnt equals MEM_TIMEOUT and mem_ready=0, the next state SHALL be ERROR and mem_err SHALL set.
REQ-012 ERROR SHALL assert pc_freeze, if_id_freeze and pipe_freeze permanently, with flushes at 0; only reset leaves ERROR.
REQ-013 wait_cnt SHALL be internal, 6 bits wide (covering MEM_TIMEOUT), and zero in RUN.
REQ-014 stall_cnt SHALL increment by 1 on each cycle with pc_freeze=1.
REQ-015 flush_cnt SHALL increment by 1 on each cycle with if_id_flush=1.
REQ-016 Both counters SHALL saturate at all-ones and never wrap.
REQ-017 clr_cnt=1 SHALL zero both counters on the next edge and SHALL take priority over a simultaneous increment.
REQ-018 The state output SHALL reflect the registered state.

Reset
REQ-019 When rst=0, the block SHALL asynchronously force state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0 and flush_cnt=0.
REQ-020 Reset asserted mid-MEM_WAIT or in ERROR SHALL abandon the wait; after release the FSM SHALL be in RUN with all outputs 0 if inputs are idle.

Structure
REQ-021 The state encodings and the defaults of CNT_W and MEM_TIMEOUT SHALL live in the shared package pipeline_ctrl_pkg.
REQ-022 The two performance counters SHALL be two instances of one sub-module, sat_counter, with ports clk, rst, clr, inc and a count output.

Verification
REQ-023 Hazard: in RUN, pulse hazard_detected=1 for 1 cycle -> pc_freeze=if_id_freeze=id_ex_flush=1 that cycle only, and stall_cnt=1.
REQ-024 Branch and hazard together: branch_taken=1 with hazard_detected=1 -> if_id_flush=id_ex_flush=1, pc_freeze=0, flush_cnt=1, stall_cnt=0.
REQ-025 Memory wait: mem_req=1 with mem_ready held 0 for 4 cycles, then 1 -> pipe_freeze=1 for 4 cycles, 0 on the ready cycle, state returns to RUN, stall_cnt=4.
REQ-026 Timeout: mem_req=1 with mem_ready never asserted -> state=ERROR after the MEM_TIMEOUT-limit cycle, mem_err=1, freezes held; rst=0 -> state=RUN, mem_err=0.
REQ-027 Saturation: with CNT_W=4, 20 hazard cycles -> stall_cnt=15; then clr_cnt=1 during a hazard cycle -> stall_cnt=0.
